// File: rtl/alu_exec_unit.sv
// Single-issue ALU execution stage with valid/ready handshakes on both sides.
// Define ALU_ITER_SHIFT_EN to make shifts iterative (one bit per cycle); otherwise a barrel shifter is used.
//
// state | meaning
// IDLE  | no result held, ready for a new operation
// EXEC  | iterative shift in progress (ALU_ITER_SHIFT_EN builds only)
// OUT   | result presented and held until downstream accepts it
module alu_exec_unit #(
    parameter int NB_DATA  = 32,
    parameter int SIZEOP   = 6,
    parameter int NB_SHAMT = 5
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [1:0]          i_aluop,
    input  logic [SIZEOP-1:0]   i_opcode,
    input  logic [SIZEOP-1:0]   i_funct,
    input  logic [NB_DATA-1:0]  i_a,
    input  logic [NB_DATA-1:0]  i_b,
    input  logic [NB_SHAMT-1:0] i_shamt,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [NB_DATA-1:0]  o_result,
    output logic                o_zero,
    output logic                o_invalid
);

    localparam logic [SIZEOP-1:0] F_SLL  = SIZEOP'(6'b000000);
    localparam logic [SIZEOP-1:0] F_SRL  = SIZEOP'(6'b000010);
    localparam logic [SIZEOP-1:0] F_SRA  = SIZEOP'(6'b000011);
    localparam logic [SIZEOP-1:0] F_SLLV = SIZEOP'(6'b000100);
    localparam logic [SIZEOP-1:0] F_SRLV = SIZEOP'(6'b000110);
    localparam logic [SIZEOP-1:0] F_SRAV = SIZEOP'(6'b000111);
    localparam logic [SIZEOP-1:0] F_ADDU = SIZEOP'(6'b100001);
    localparam logic [SIZEOP-1:0] F_SUBU = SIZEOP'(6'b100011);
    localparam logic [SIZEOP-1:0] F_AND  = SIZEOP'(6'b100100);
    localparam logic [SIZEOP-1:0] F_OR   = SIZEOP'(6'b100101);
    localparam logic [SIZEOP-1:0] F_XOR  = SIZEOP'(6'b100110);
    localparam logic [SIZEOP-1:0] F_NOR  = SIZEOP'(6'b100111);
    localparam logic [SIZEOP-1:0] F_SLT  = SIZEOP'(6'b101010);
    localparam logic [SIZEOP-1:0] O_ADDI = SIZEOP'(6'b001000);
    localparam logic [SIZEOP-1:0] O_SLTI = SIZEOP'(6'b001010);
    localparam logic [SIZEOP-1:0] O_ANDI = SIZEOP'(6'b001100);
    localparam logic [SIZEOP-1:0] O_ORI  = SIZEOP'(6'b001101);
    localparam logic [SIZEOP-1:0] O_XORI = SIZEOP'(6'b001110);
    localparam logic [SIZEOP-1:0] O_LUI  = SIZEOP'(6'b001111);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef ALU_ITER_SHIFT_EN
        EXEC = 2'd2,
`endif
        OUT  = 2'd1
    } state_t;

    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shkind_t;

    state_t               state_q, state_d;
    logic [NB_DATA-1:0]   result_q, result_d;
    logic                 invalid_q, invalid_d;
    logic [NB_DATA-1:0]   alu_res;
    logic                 alu_inv;
    logic                 is_shift;
    logic [NB_SHAMT-1:0]  sh_amt;
    shkind_t              sh_kind;
    logic                 accept;

`ifdef ALU_ITER_SHIFT_EN
    logic [NB_SHAMT-1:0]  cnt_q, cnt_d;
    shkind_t              kind_q, kind_d;
    logic [NB_DATA-1:0]   step;
`endif

    assign o_ready   = ~i_reset & ((state_q == IDLE) | ((state_q == OUT) & i_ready));
    assign accept    = i_valid & o_ready;
    assign o_valid   = (state_q == OUT);
    assign o_result  = result_q;
    assign o_zero    = ~|result_q;
    assign o_invalid = invalid_q;

    always_comb begin
        alu_res  = '0;
        alu_inv  = 1'b0;
        is_shift = 1'b0;
        sh_amt   = i_shamt;
        sh_kind  = SH_LL;
        case (i_aluop)
            2'b00: alu_res = i_a + i_b;
            2'b01: alu_res = i_a - i_b;
            2'b10: begin
                case (i_funct)
                    F_SLL:  begin is_shift = 1'b1; sh_kind = SH_LL; end
                    F_SRL:  begin is_shift = 1'b1; sh_kind = SH_RL; end
                    F_SRA:  begin is_shift = 1'b1; sh_kind = SH_RA; end
                    F_SLLV: begin is_shift = 1'b1; sh_kind = SH_LL; sh_amt = i_a[NB_SHAMT-1:0]; end
                    F_SRLV: begin is_shift = 1'b1; sh_kind = SH_RL; sh_amt = i_a[NB_SHAMT-1:0]; end
                    F_SRAV: begin is_shift = 1'b1; sh_kind = SH_RA; sh_amt = i_a[NB_SHAMT-1:0]; end
                    F_ADDU: alu_res = i_a + i_b;
                    F_SUBU: alu_res = i_a - i_b;
                    F_AND:  alu_res = i_a & i_b;
                    F_OR:   alu_res = i_a | i_b;
                    F_XOR:  alu_res = i_a ^ i_b;
                    F_NOR:  alu_res = ~(i_a | i_b);
                    F_SLT:  alu_res = {{(NB_DATA-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
                    default: alu_inv = 1'b1;
                endcase
            end
            default: begin
                case (i_opcode)
                    O_ADDI: alu_res = i_a + i_b;
                    O_ANDI: alu_res = i_a & i_b;
                    O_ORI:  alu_res = i_a | i_b;
                    O_XORI: alu_res = i_a ^ i_b;
                    O_SLTI: alu_res = {{(NB_DATA-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
                    O_LUI:  alu_res = {i_b[NB_DATA/2-1:0], {(NB_DATA/2){1'b0}}};
                    default: alu_inv = 1'b1;
                endcase
            end
        endcase
        if (is_shift) begin
`ifdef ALU_ITER_SHIFT_EN
            // Operand is loaded unshifted; EXEC walks it one bit per cycle (s=0 finishes here)
            alu_res = i_b;
`else
            case (sh_kind)
                SH_LL:   alu_res = i_b << sh_amt;
                SH_RL:   alu_res = i_b >> sh_amt;
                default: alu_res = $signed(i_b) >>> sh_amt;
            endcase
`endif
        end
    end

`ifdef ALU_ITER_SHIFT_EN
    always_comb begin
        case (kind_q)
            SH_LL:   step = {result_q[NB_DATA-2:0], 1'b0};
            SH_RL:   step = {1'b0, result_q[NB_DATA-1:1]};
            default: step = {result_q[NB_DATA-1], result_q[NB_DATA-1:1]};
        endcase
    end
`endif

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        invalid_d = invalid_q;
`ifdef ALU_ITER_SHIFT_EN
        cnt_d     = cnt_q;
        kind_d    = kind_q;
`endif
        case (state_q)
            IDLE, OUT: begin
                if (accept) begin
                    result_d  = alu_res;
                    invalid_d = alu_inv;
                    state_d   = OUT;
`ifdef ALU_ITER_SHIFT_EN
                    if (is_shift && (sh_amt != '0)) begin
                        cnt_d   = sh_amt;
                        kind_d  = sh_kind;
                        state_d = EXEC;
                    end
`endif
                end else if ((state_q == OUT) && i_ready) begin
                    state_d = IDLE;
                end
            end
`ifdef ALU_ITER_SHIFT_EN
            EXEC: begin
                result_d = step;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == NB_SHAMT'(1)) state_d = OUT;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            result_q  <= '0;
            invalid_q <= 1'b0;
`ifdef ALU_ITER_SHIFT_EN
            cnt_q     <= '0;
            kind_q    <= SH_LL;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            invalid_q <= invalid_d;
`ifdef ALU_ITER_SHIFT_EN
            cnt_q     <= cnt_d;
            kind_q    <= kind_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: driver pushes reference results, a monitor pops on each output handshake.
module tb_alu_exec_unit;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_aluop;
    logic [5:0]  i_opcode;
    logic [5:0]  i_funct;
    logic [31:0] i_a, i_b;
    logic [4:0]  i_shamt;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_zero;
    logic        o_invalid;

    always #5 i_clock = ~i_clock;

    alu_exec_unit dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_aluop(i_aluop), .i_opcode(i_opcode), .i_funct(i_funct),
        .i_a(i_a), .i_b(i_b), .i_shamt(i_shamt),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
        .o_zero(o_zero), .o_invalid(o_invalid)
    );

    typedef struct packed {
        logic        inv;
        logic [31:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   rand_ready  = 1'b0;
    bit   ready_force = 1'b1;

    logic [5:0] funct_list[13] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                   6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
    logic [5:0] opc_list[6]    = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0F};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Shifts expressed as multiplication/division by powers of two
    function automatic logic [31:0] m_shl(input logic [31:0] b, input int s);
        return 32'(64'(b) * (64'd1 << s));
    endfunction
    function automatic logic [31:0] m_shr(input logic [31:0] b, input int s);
        return b / (32'd1 << s);
    endfunction
    function automatic logic [31:0] m_sra(input logic [31:0] b, input int s);
        if (b[31]) return ~((~b) / (32'd1 << s));
        return b / (32'd1 << s);
    endfunction

    function automatic exp_t model(input logic [1:0] op, input logic [5:0] opc, input logic [5:0] fn,
                                   input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        exp_t e;
        int   sa, sb, va;
        sa = a;
        sb = b;
        va = int'(a % 32);
        e.inv = 1'b0;
        e.res = '0;
        case (op)
            2'd0: e.res = a + b;
            2'd1: e.res = a - b;
            2'd2: begin
                case (fn)
                    6'h00: e.res = m_shl(b, int'(sh));
                    6'h02: e.res = m_shr(b, int'(sh));
                    6'h03: e.res = m_sra(b, int'(sh));
                    6'h04: e.res = m_shl(b, va);
                    6'h06: e.res = m_shr(b, va);
                    6'h07: e.res = m_sra(b, va);
                    6'h21: e.res = a + b;
                    6'h23: e.res = a - b;
                    6'h24: e.res = a & b;
                    6'h25: e.res = a | b;
                    6'h26: e.res = a ^ b;
                    6'h27: e.res = ~(a | b);
                    6'h2A: e.res = (sa < sb) ? 32'd1 : 32'd0;
                    default: e.inv = 1'b1;
                endcase
            end
            default: begin
                case (opc)
                    6'h08: e.res = a + b;
                    6'h0C: e.res = a & b;
                    6'h0D: e.res = a | b;
                    6'h0E: e.res = a ^ b;
                    6'h0A: e.res = (sa < sb) ? 32'd1 : 32'd0;
                    6'h0F: e.res = b * 32'd65536;
                    default: e.inv = 1'b1;
                endcase
            end
        endcase
        return e;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [5:0] opc, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        logic acc;
        int   n;
        i_aluop = op; i_opcode = opc; i_funct = fn;
        i_a = a; i_b = b; i_shamt = sh;
        i_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge i_clock);
            acc = o_ready;
            @(posedge i_clock);
            n++;
        end
        if (!acc) begin
            n_chk++;
            $display("FAIL accept_timeout: o_ready got 0 for 200 cycles, expected 1");
        end else begin
            exp_q.push_back(model(op, opc, fn, a, b, sh));
        end
        #1 i_valid = 1'b0;
    endtask

    task automatic sync();
        @(posedge i_clock);
        #1;
    endtask

    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge i_clock);
            #1;
            i_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge i_clock);
            if (!i_reset && o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_output: got %h expected no result", o_result);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", {30'd0, o_invalid, o_zero, o_result},
                        {30'd0, e.inv, (e.res == 32'd0), e.res});
                end
            end
        end
    end

    initial begin
        logic [1:0]  op;
        logic [5:0]  opc, fn;
        logic [31:0] a, b;
        int          k;

        i_reset = 1'b1; i_valid = 1'b0; i_aluop = '0; i_opcode = '0; i_funct = '0;
        i_a = '0; i_b = '0; i_shamt = '0;
        repeat (3) @(posedge i_clock);
        @(negedge i_clock);
        chk("rst_ready", o_ready, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_flags", {o_invalid, o_zero, o_result}, {1'b0, 1'b1, 32'd0});
        i_reset = 1'b0;
        sync();

        issue(2'b10, 6'h00, 6'h21, 32'hFFFF_FFFF, 32'd2, 5'd0);
        @(negedge i_clock);
        chk("addu_valid", o_valid, 1);
        chk("addu_res", {o_zero, o_result}, {1'b0, 32'd1});
        sync();

        issue(2'b01, 6'h00, 6'h00, 32'h1234, 32'h1234, 5'd0);
        @(negedge i_clock);
        chk("sub_zero", {o_zero, o_result}, {1'b1, 32'd0});
        sync();
        issue(2'b11, 6'h0F, 6'h00, 32'd0, 32'h0000_ABCD, 5'd0);
        @(negedge i_clock);
        chk("lui", o_result, 32'hABCD_0000);
        sync();

        issue(2'b10, 6'h00, 6'h2A, 32'h8000_0000, 32'd1, 5'd0);
        @(negedge i_clock);
        chk("slt", o_result, 32'd1);
        sync();
        issue(2'b10, 6'h00, 6'h3F, 32'h8000_0000, 32'd1, 5'd0);
        @(negedge i_clock);
        chk("invalid", {o_invalid, o_zero, o_result}, {1'b1, 1'b1, 32'd0});
        sync();

        ready_force = 1'b0;
        sync();
        issue(2'b00, 6'h00, 6'h00, 32'd5, 32'd7, 5'd0);
        fork
            issue(2'b11, 6'h0D, 6'h00, 32'hF0, 32'h0F, 5'd0);
            begin
                repeat (3) begin
                    @(negedge i_clock);
                    chk("stall_hold", {o_valid, o_ready, o_result}, {1'b1, 1'b0, 32'd12});
                end
                ready_force = 1'b1;
            end
        join
        @(negedge i_clock);
        chk("stall_release", o_result, 32'hFF);
        sync();

`ifdef ALU_ITER_SHIFT_EN
        issue(2'b10, 6'h00, 6'h03, 32'd0, 32'h8000_0000, 5'd4);
        repeat (4) begin
            @(negedge i_clock);
            chk("iter_busy", {o_ready, o_valid}, {1'b0, 1'b0});
            @(posedge i_clock);
        end
        @(negedge i_clock);
        chk("iter_done", {o_valid, o_result}, {1'b1, 32'hF800_0000});
        sync();
        issue(2'b10, 6'h00, 6'h03, 32'd0, 32'h8000_0000, 5'd4);
        @(negedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b1;
        #1;
        chk("iter_rst", {o_ready, o_valid, o_result}, {1'b0, 1'b0, 32'd0});
        @(negedge i_clock);
        i_reset = 1'b0;
        exp_q.delete();
        repeat (6) @(negedge i_clock);
        chk("iter_no_replay", o_valid, 0);
        sync();
`endif

        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op  = 2'($urandom_range(0, 3));
            fn  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : funct_list[$urandom_range(0, 12)];
            opc = ($urandom_range(0, 9) == 0) ? 6'($urandom) : opc_list[$urandom_range(0, 5)];
            a   = $urandom;
            b   = ($urandom_range(0, 7) == 0) ? a : $urandom;
            issue(op, opc, fn, a, b, 5'($urandom));
        end

        rand_ready  = 1'b0;
        ready_force = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(posedge i_clock);
            k++;
        end
        chk("drain", exp_q.size(), 0);
        @(negedge i_clock);
        chk("idle_after_drain", o_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter NB_DATA, default 32, datapath width in bits; SHALL be even and at least 8.
REQ-002 Parameter SIZEOP, default 6, opcode and funct field width.
REQ-003 Parameter NB_SHAMT, default 5, shift-amount width; SHALL equal log2(NB_DATA).
REQ-004 i_clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_valid  in  1  upstream operation valid.
REQ-007 o_ready  out  1  unit can accept an operation this cycle.
REQ-008 i_aluop  in  2  00 load/store add, 01 branch subtract, 10 R-type via funct, 11 I-type via opcode.
REQ-009 i_opcode  in  SIZEOP  instruction opcode.
REQ-010 i_funct  in  SIZEOP  R-type funct field.
REQ-011 i_a, i_b  in  NB_DATA each  operand A (rs) and operand B (rt or immediate).
REQ-012 i_shamt  in  NB_SHAMT  immediate shift amount.
REQ-013 o_valid  out  1  result valid.
REQ-014 i_ready  in  1  downstream accepts the result.
REQ-015 o_result  out  NB_DATA  registered result.
REQ-016 o_zero  out  1  high when o_result is all zeros.
REQ-017 o_invalid  out  1  the operation was unsupported; o_result is 0.

Function
REQ-018 An operation is accepted on an edge where i_valid and o_ready are both high; operands and decode SHALL be captured on that edge.
REQ-019 Decode by aluop:
- 00: a+b.
- 01: a-b.
- 10, funct decode: SLL 000000, SRL 000010, SRA 000011 shift b by i_shamt; SLLV 000100, SRLV 000110, SRAV 000111 shift b by a[NB_SHAMT-1:0]; ADDU 100001; SUBU 100011; AND 100100; OR 100101; XOR 100110; NOR 100111; SLT 101010.
- 11, opcode decode: ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, SLTI 001010, LUI 001111.
REQ-020 Add and subtract SHALL wrap modulo 2^NB_DATA with no overflow flag; SLT and SLTI SHALL compare signed and return 1 or 0 zero-extended.
REQ-021 LUI SHALL return b[NB_DATA/2-1:0] concatenated with NB_DATA/2 zero bits; SRA and SRAV SHALL replicate b[NB_DATA-1].
REQ-022 An unsupported funct or opcode SHALL still complete with o_result=0, o_zero=1 and o_invalid=1.
REQ-023 The FSM SHALL have three states:
- IDLE: o_ready=1, o_valid=0.
- EXEC: o_ready=0, o_valid=0; exists only with the Configuration macro.
- OUT: o_valid=1; o_result, o_zero and o_invalid SHALL be held stable until the result is accepted.
REQ-024 Non-iterative operations go IDLE->OUT on the accept edge; latency is 1 cycle.
REQ-025 In OUT, o_ready SHALL equal i_ready; on i_ready & i_valid a new operation is accepted and the state stays OUT, giving back-to-back throughput of one per cycle.
REQ-026 In OUT, i_ready with no i_valid SHALL return the state to IDLE and drop o_valid on the next edge.
REQ-027 In OUT, while i_ready=0 the state SHALL hold regardless of i_valid, and o_ready SHALL be 0.

Reset
REQ-028 While i_reset is high: state=IDLE, o_valid=0, o_result=0, o_zero=1, o_invalid=0, shift counter=0; o_ready SHALL be 0 while reset is asserted.
REQ-029 Assertion of i_reset mid-operation, in EXEC or OUT, SHALL discard the in-flight operation; nothing is replayed.

Configuration
REQ-030 With macro ALU_ITER_SHIFT_EN defined, all six shifts SHALL be iterative, one bit per cycle:
- Shift amount s=0: behaves as REQ-024.
- s>0: accept edge loads b and counter=s and enters EXEC; each edge shifts one bit and decrements; the edge that reaches 0 enters OUT.
- o_valid is therefore visible s+1 edges after acceptance.
REQ-031 Without ALU_ITER_SHIFT_EN, shifts SHALL use a single-cycle barrel shifter with 1-cycle latency, and the EXEC state SHALL not exist.

Verification
REQ-032 aluop=10, funct=100001, a=0xFFFFFFFF, b=2, i_ready=1 -> next cycle o_valid=1, o_result=0x00000001, o_zero=0.
REQ-033 aluop=01, a=b=0x1234 -> o_result=0, o_zero=1; then aluop=11, opcode=001111, b=0x0000ABCD -> o_result=0xABCD0000.
REQ-034 aluop=10, funct=101010, a=0x80000000, b=1 -> o_result=1; funct=111111 -> o_result=0, o_invalid=1.
REQ-035 Result in OUT with i_ready=0 for 3 cycles while i_valid=1 -> o_result stable, o_ready=0, no accept; i_ready=1 -> new operation accepted on that edge.
REQ-036 ALU_ITER_SHIFT_EN, SRA, b=0x80000000, shamt=4 -> o_ready low 4 cycles, o_valid after the 5th edge, o_result=0xF8000000; repeat with i_reset pulsed in EXEC -> IDLE, o_valid=0, o_result=0.
